mem_arb_2p: RTL and testbench

Two-port arbiter that shares the single-ported zero-latency data memory between the core's instruction-fetch port (port 0, read-only) and its load/store port (port 1, read/write with byte strobes). Each cycle it grants at most one request, drives the memory combinationally in the grant cycle, and registers the read data. It returns a one-cycle response pulse to the granted port on the following cycle, and flags out-of-range addresses instead of forwarding them.

---
 rtl/mem_arb_2p_if.sv | 39 +++
 rtl/mem_arb_2p.sv | 109 ++++++++++
 tb/tb_mem_arb_2p.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_2p_if.sv
// Requester-side bundle for mem_arb_2p: fetch port p0 and load/store port p1.
// master = core requesters, slave = arbiter.
interface mem_arb_2p_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int SW = DATA_WIDTH / 8;

    logic                  p0_req;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic                  p0_gnt;
    logic                  p0_rvalid;
    logic [DATA_WIDTH-1:0] p0_rdata;
    logic                  p0_err;

    logic                  p1_req;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic                  p1_we;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic [SW-1:0]         p1_wstrb;
    logic                  p1_gnt;
    logic                  p1_rvalid;
    logic [DATA_WIDTH-1:0] p1_rdata;
    logic                  p1_err;

    modport master (
        output p0_req, p0_addr,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_addr, p1_we, p1_wdata, p1_wstrb,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err
    );

    modport slave (
        input  p0_req, p0_addr,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_addr, p1_we, p1_wdata, p1_wstrb,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err
    );
endinterface

// File: rtl/mem_arb_2p.sv
// Two-port arbiter sharing a zero-latency single-ported data memory.
// Define MEM_ARB_RR_EN for round-robin; otherwise port 1 has fixed priority.
module mem_arb_2p #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mem_arb_2p_if.slave                 bus,
    output logic [$clog2(DEPTH)-1:0]    mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    output logic [DATA_WIDTH/8-1:0]     mem_wstrb,
    output logic                        mem_write,
    output logic                        mem_read,
    input  logic [DATA_WIDTH-1:0]       mem_rdata
);
    localparam int MEM_AW = $clog2(DEPTH);
    localparam int WB     = $clog2(DATA_WIDTH / 8);
    localparam int TOP    = MEM_AW + WB;

    logic              gnt0, gnt1, acc, oor0, oor1, sel_oor;
    logic [MEM_AW-1:0] idx0, idx1, sel_idx, addr_q;

    logic                  v0_q, e0_q, v1_q, e1_q;
    logic [DATA_WIDTH-1:0] r0_q, r1_q;

    logic unused_ok;
    assign unused_ok = ^{bus.p0_addr[WB-1:0], bus.p1_addr[WB-1:0]};

    assign idx0 = bus.p0_addr[TOP-1:WB];
    assign idx1 = bus.p1_addr[TOP-1:WB];
    assign oor0 = |bus.p0_addr[ADDR_WIDTH-1:TOP];
    assign oor1 = |bus.p1_addr[ADDR_WIDTH-1:TOP];

`ifdef MEM_ARB_RR_EN
    // last_q = 1 means port 1 was granted most recently
    logic last_q;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (bus.p0_req && bus.p1_req) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = bus.p0_req;
                gnt1 = bus.p1_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_q <= 1'b1;
        else if (gnt0)
            last_q <= 1'b0;
        else if (gnt1)
            last_q <= 1'b1;
    end
`else
    assign gnt1 = rst_n & bus.p1_req;
    assign gnt0 = rst_n & bus.p0_req & ~bus.p1_req;
`endif

    assign acc     = gnt0 | gnt1;
    assign sel_idx = gnt1 ? idx1 : idx0;
    assign sel_oor = gnt1 ? oor1 : oor0;

    assign mem_addr  = acc ? sel_idx : addr_q;
    assign mem_write = gnt1 & bus.p1_we & ~oor1;
    assign mem_read  = acc & ~sel_oor & ~(gnt1 & bus.p1_we);
    assign mem_wdata = mem_write ? bus.p1_wdata : '0;
    assign mem_wstrb = mem_write ? bus.p1_wstrb : '0;

    assign bus.p0_gnt    = gnt0;
    assign bus.p0_rvalid = v0_q;
    assign bus.p0_rdata  = r0_q;
    assign bus.p0_err    = e0_q;
    assign bus.p1_gnt    = gnt1;
    assign bus.p1_rvalid = v1_q;
    assign bus.p1_rdata  = r1_q;
    assign bus.p1_err    = e1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            v0_q   <= 1'b0;
            e0_q   <= 1'b0;
            r0_q   <= '0;
            v1_q   <= 1'b0;
            e1_q   <= 1'b0;
            r1_q   <= '0;
        end else begin
            v0_q <= gnt0;
            e0_q <= gnt0 & oor0;
            v1_q <= gnt1;
            e1_q <= gnt1 & oor1;
            if (acc)
                addr_q <= sel_idx;
            if (gnt0)
                r0_q <= oor0 ? '0 : mem_rdata;
            // write acks and errors return zero data
            if (gnt1)
                r1_q <= (oor1 || bus.p1_we) ? '0 : mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arb_2p.sv
// Directed testbench for mem_arb_2p with a behavioural zero-latency memory.
// Conflict expectations follow MEM_ARB_RR_EN.
module tb_mem_arb_2p;
    logic        clk;
    logic        rst_n;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    logic [31:0] ram [1024];

    int errs;
    int checks;

    mem_arb_2p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_arb_2p #(
        .DATA_WIDTH(32),
        .DEPTH(1024),
        .ADDR_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_write(mem_write),
        .mem_read(mem_read),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b])
                    ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.p0_req   = 1'b0;
        bus.p0_addr  = '0;
        bus.p1_req   = 1'b0;
        bus.p1_addr  = '0;
        bus.p1_we    = 1'b0;
        bus.p1_wdata = '0;
        bus.p1_wstrb = '0;
    endtask

    initial begin
        logic e0, e1;
        errs   = 0;
        checks = 0;
        for (int i = 0; i < 1024; i++)
            ram[i] = '0;
        ram[5] = 32'hDEADBEEF;
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_p0_rvalid", bus.p0_rvalid, 0);
        chk("rst_p1_rvalid", bus.p1_rvalid, 0);
        chk("rst_p0_rdata", bus.p0_rdata, 0);
        chk("rst_p1_err", bus.p1_err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_read", mem_read, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single fetch
        @(negedge clk);
        bus.p0_req  = 1'b1;
        bus.p0_addr = 32'h14;
        #1;
        chk("f_gnt", bus.p0_gnt, 1);
        chk("f_mem_read", mem_read, 1);
        chk("f_mem_addr", mem_addr, 5);
        @(posedge clk);
        #1;
        idle();
        chk("f_rvalid", bus.p0_rvalid, 1);
        chk("f_rdata", bus.p0_rdata, 32'hDEADBEEF);
        chk("f_err", bus.p0_err, 0);
        @(posedge clk);
        #1;
        chk("f_rvalid_n2", bus.p0_rvalid, 0);
        chk("f_rdata_hold", bus.p0_rdata, 32'hDEADBEEF);
        chk("idle_mem_addr", mem_addr, 5);
        chk("idle_mem_read", mem_read, 0);
        chk("idle_wdata", mem_wdata, 0);

        // strobed write
        @(negedge clk);
        bus.p1_req   = 1'b1;
        bus.p1_addr  = 32'h20;
        bus.p1_we    = 1'b1;
        bus.p1_wdata = 32'h11223344;
        bus.p1_wstrb = 4'b0101;
        #1;
        chk("w_gnt", bus.p1_gnt, 1);
        chk("w_mem_write", mem_write, 1);
        chk("w_mem_read", mem_read, 0);
        chk("w_mem_wstrb", mem_wstrb, 4'b0101);
        @(posedge clk);
        #1;
        idle();
        chk("w_rvalid", bus.p1_rvalid, 1);
        chk("w_rdata", bus.p1_rdata, 0);
        chk("w_ram", ram[8], 32'h00220044);

        // read back
        @(negedge clk);
        bus.p1_req  = 1'b1;
        bus.p1_addr = 32'h20;
        #1;
        chk("r_gnt", bus.p1_gnt, 1);
        @(posedge clk);
        #1;
        idle();
        chk("r_rvalid", bus.p1_rvalid, 1);
        chk("r_rdata", bus.p1_rdata, 32'h00220044);

        // conflict: both ports request for 4 cycles
        @(negedge clk);
        bus.p0_req  = 1'b1;
        bus.p0_addr = 32'h14;
        bus.p1_req  = 1'b1;
        bus.p1_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef MEM_ARB_RR_EN
            e0 = (i % 2) == 0;
`else
            e0 = 1'b0;
`endif
            e1 = !e0;
            chk($sformatf("c%0d_p0_gnt", i), bus.p0_gnt, e0);
            chk($sformatf("c%0d_p1_gnt", i), bus.p1_gnt, e1);
            @(negedge clk);
        end
        idle();
        @(posedge clk);
        #1;

        // out of range
        @(negedge clk);
        bus.p1_req  = 1'b1;
        bus.p1_addr = 32'h1000;
        #1;
        chk("oor_gnt", bus.p1_gnt, 1);
        chk("oor_mem_read", mem_read, 0);
        chk("oor_mem_write", mem_write, 0);
        @(posedge clk);
        #1;
        idle();
        chk("oor_rvalid", bus.p1_rvalid, 1);
        chk("oor_err", bus.p1_err, 1);
        chk("oor_rdata", bus.p1_rdata, 0);

        // misaligned fetch
        @(negedge clk);
        bus.p0_req  = 1'b1;
        bus.p0_addr = 32'h17;
        #1;
        chk("mis_mem_addr", mem_addr, 5);
        @(posedge clk);
        #1;
        idle();
        chk("mis_rvalid", bus.p0_rvalid, 1);
        chk("mis_rdata", bus.p0_rdata, 32'hDEADBEEF);

        // reset while a response is in flight
        @(negedge clk);
        bus.p0_req  = 1'b1;
        bus.p0_addr = 32'h14;
        #1;
        chk("rf_gnt", bus.p0_gnt, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rf_gnt_in_rst", bus.p0_gnt, 0);
        chk("rf_read_in_rst", mem_read, 0);
        @(posedge clk);
        #1;
        idle();
        chk("rf_rvalid", bus.p0_rvalid, 0);
        chk("rf_rdata", bus.p0_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rf_quiet%0d", i), bus.p0_rvalid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
